rle_engine: RTL and testbench

Parametrised run-length encoder, the next generation of the frame RLE compressor. It reads a plaintext frame word by word from the shared dual-port SRAM (port A) and scans symbols at one symbol per clock. It emits (count, symbol) pairs packed into 32-bit words, written back to the same port at `rle_addr`. It sits beside the host interface, is launched by `start`, and reports `done` and `rle_size`.

---
 rtl/rle_engine_if.sv | 28 ++
 rtl/rle_engine.sv | 254 +++++++++++++++++++++++++
 tb/tb_rle_engine.sv | 375 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rle_engine_if.sv
// rle_engine_if: SRAM port A bundle shared by the RLE engine and the dual-port SRAM.
// The engine drives address, write data, write enable and the port clock.
// The SRAM returns read data one cycle after a read address is presented.
interface rle_engine_if #(
    parameter int ADDR_W = 16
);
    logic              port_A_clk;
    logic [ADDR_W-1:0] port_A_addr;
    logic [31:0]       port_A_data_in;
    logic [31:0]       port_A_data_out;
    logic              port_A_we;

    modport master (
        output port_A_clk,
        output port_A_addr,
        output port_A_data_in,
        output port_A_we,
        input  port_A_data_out
    );

    modport slave (
        input  port_A_clk,
        input  port_A_addr,
        input  port_A_data_in,
        input  port_A_we,
        output port_A_data_out
    );
endinterface

// File: rtl/rle_engine.sv
// rle_engine: run-length encoder working out of SRAM port A.
// Reads a plaintext frame one 32-bit word at a time, scans one symbol per
// cycle, and writes {count, symbol} pairs packed little-endian into 32-bit
// words at rle_addr.
// Optional feature macro: RLE_ABORT_EN adds the abort input and the aborted
// status output.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | waiting for start
// S_RD_REQ  | read address on port A for one cycle
// S_RD_WAIT | read data returns and is captured at the end of the cycle
// S_SCAN    | one symbol per cycle through the captured word
// S_WR      | one-cycle write of the packed output word
// S_FLUSH   | close the open run at the end of the frame
// S_DONE    | frame complete, done high, start relaunches
module rle_engine #(
    parameter int SYMBOL_W = 8,
    parameter int COUNT_W  = 8,
    parameter int ADDR_W   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] message_addr,
    input  logic [31:0] message_size,
    input  logic [31:0] rle_addr,
    output logic [31:0] rle_size,
    output logic        done,
`ifdef RLE_ABORT_EN
    input  logic        abort,
    output logic        aborted,
`endif
    rle_engine_if.master port_a
);

    localparam int PAIR_W         = SYMBOL_W + COUNT_W;
    localparam int SYMS_PER_WORD  = 32 / SYMBOL_W;
    localparam int PAIRS_PER_WORD = 32 / PAIR_W;
    localparam int SYM_BYTES      = SYMBOL_W / 8;
    localparam int PAIR_BYTES     = PAIR_W / 8;
    localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};

    // Only 8/16-bit symbols and counts whose pair fills half or all of a word.
    generate
        if (!((SYMBOL_W == 8 || SYMBOL_W == 16) &&
              (COUNT_W == 8 || COUNT_W == 16) &&
              (PAIR_W == 16 || PAIR_W == 32))) begin : g_bad_widths
            $error("rle_engine: SYMBOL_W + COUNT_W must be 16 or 32 with 8/16-bit fields");
        end
        if (ADDR_W < 3 || ADDR_W > 32) begin : g_bad_addr
            $error("rle_engine: ADDR_W must lie in 3..32");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_SCAN,
        S_WR,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t              state;
    state_t              state_nx;
    state_t              pend_state;
    state_t              after_scan;
    state_t              launch_state;

    logic [ADDR_W-1:0]   rd_addr;
    logic [ADDR_W-1:0]   wr_addr;
    logic [ADDR_W-1:0]   msg_base;
    logic [ADDR_W-1:0]   rle_base;
    logic [31:0]         bytes_left;
    logic [31:0]         in_word;
    logic [31:0]         sym_word;
    logic [1:0]          sym_idx;
    logic                run_valid;
    logic [SYMBOL_W-1:0] run_sym;
    logic [COUNT_W-1:0]  run_cnt;
    logic [SYMBOL_W-1:0] cur_sym;
    logic [31:0]         out_word;
    logic [31:0]         pair_word;
    logic [1:0]          slot_cnt;
    logic                frame_end;
    logic                word_last;
    logic                scan_emit;
    logic                emit;
    logic                word_full;
    logic                abort_hit;
    logic                unused_addr_bits;

    // Byte addresses are word aligned and taken modulo 2^ADDR_W; upper bits are dropped.
    assign msg_base         = {message_addr[ADDR_W-1:2], 2'b00};
    assign rle_base         = {rle_addr[ADDR_W-1:2], 2'b00};
    assign unused_addr_bits = ^{message_addr, rle_addr};

    assign port_a.port_A_clk = clk;

`ifdef RLE_ABORT_EN
    assign abort_hit = abort && (state != S_IDLE) && (state != S_DONE);
`else
    assign abort_hit = 1'b0;
`endif

    // Symbol selection, run comparison and pair placement for the current cycle.
    always_comb begin
        sym_word     = in_word >> (32'(sym_idx) * 32'(SYMBOL_W));
        cur_sym      = sym_word[SYMBOL_W-1:0];
        frame_end    = (bytes_left <= 32'(SYM_BYTES));
        word_last    = (sym_idx == 2'(SYMS_PER_WORD - 1));
        // A new symbol or a saturated counter closes the current run.
        scan_emit    = run_valid && ((cur_sym != run_sym) || (run_cnt == COUNT_MAX));
        emit         = ((state == S_SCAN) && scan_emit) || ((state == S_FLUSH) && run_valid);
        word_full    = emit && (slot_cnt == 2'(PAIRS_PER_WORD - 1));
        pair_word    = 32'({run_cnt, run_sym}) << (32'(slot_cnt) * 32'(PAIR_W));
        launch_state = (message_size == 32'd0) ? S_FLUSH : S_RD_REQ;
        if (frame_end) begin
            after_scan = S_FLUSH;
        end else if (word_last) begin
            after_scan = S_RD_REQ;
        end else begin
            after_scan = S_SCAN;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode; a write always preempts the state the scan would go to next.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (start) state_nx = launch_state;
            S_RD_REQ:  state_nx = S_RD_WAIT;
            S_RD_WAIT: state_nx = S_SCAN;
            S_SCAN:    state_nx = word_full ? S_WR : after_scan;
            S_WR:      state_nx = pend_state;
            S_FLUSH:   state_nx = (run_valid || (slot_cnt != 2'd0)) ? S_WR : S_DONE;
            S_DONE:    if (start) state_nx = launch_state;
            default:   state_nx = S_IDLE;
        endcase
        if (abort_hit) begin
            state_nx = S_DONE;
        end
    end

    // Port A and status outputs decoded from the state; everything idles at zero.
    always_comb begin
        port_a.port_A_we      = 1'b0;
        port_a.port_A_addr    = '0;
        port_a.port_A_data_in = 32'd0;
        done                  = 1'b0;
        case (state)
            S_RD_REQ: port_a.port_A_addr = rd_addr;
            S_WR: begin
                port_a.port_A_we      = 1'b1;
                port_a.port_A_addr    = wr_addr;
                port_a.port_A_data_in = out_word;
            end
            S_DONE:   done = 1'b1;
            default: ;
        endcase
    end

    // Datapath: address counters, run tracking, output packing and size accounting.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_state <= S_IDLE;
            rd_addr    <= '0;
            wr_addr    <= '0;
            bytes_left <= 32'd0;
            in_word    <= 32'd0;
            sym_idx    <= 2'd0;
            run_valid  <= 1'b0;
            run_sym    <= '0;
            run_cnt    <= '0;
            out_word   <= 32'd0;
            slot_cnt   <= 2'd0;
            rle_size   <= 32'd0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        rd_addr    <= msg_base;
                        wr_addr    <= rle_base;
                        bytes_left <= message_size;
                        run_valid  <= 1'b0;
                        out_word   <= 32'd0;
                        slot_cnt   <= 2'd0;
                        rle_size   <= 32'd0;
                    end
                end
                S_RD_REQ: begin
                    rd_addr <= rd_addr + ADDR_W'(4);
                end
                S_RD_WAIT: begin
                    in_word <= port_a.port_A_data_out;
                    sym_idx <= 2'd0;
                end
                S_SCAN: begin
                    bytes_left <= bytes_left - 32'(SYM_BYTES);
                    sym_idx    <= sym_idx + 2'd1;
                    pend_state <= after_scan;
                    if (!run_valid || scan_emit) begin
                        run_valid <= 1'b1;
                        run_sym   <= cur_sym;
                        run_cnt   <= COUNT_W'(1);
                    end else begin
                        run_cnt <= run_cnt + COUNT_W'(1);
                    end
                end
                S_FLUSH: begin
                    pend_state <= S_DONE;
                    run_valid  <= 1'b0;
                end
                S_WR: begin
                    // Size only counts pairs that actually reach memory.
                    rle_size <= rle_size + 32'(32'(slot_cnt) * 32'(PAIR_BYTES));
                    wr_addr  <= wr_addr + ADDR_W'(4);
                    out_word <= 32'd0;
                    slot_cnt <= 2'd0;
                end
                default: ;
            endcase
            if (emit) begin
                out_word <= out_word | pair_word;
                slot_cnt <= slot_cnt + 2'd1;
            end
        end
    end

`ifdef RLE_ABORT_EN
    // Abort flag: set when a frame is cut short, cleared on the next launch.
    always_ff @(posedge clk) begin
        if (reset) begin
            aborted <= 1'b0;
        end else if (abort_hit) begin
            aborted <= 1'b1;
        end else if (((state == S_IDLE) || (state == S_DONE)) && start) begin
            aborted <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_rle_engine.sv
// tb_rle_engine: directed and randomized checks of rle_engine in 8/8 and 16/16
// builds sharing one SRAM model; expected output comes from a pair-list model.
module tb_rle_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start;
    logic        sel;
    logic [31:0] message_addr;
    logic [31:0] message_size;
    logic [31:0] rle_addr;
    logic [31:0] rle_size8;
    logic [31:0] rle_size16;
    logic        done8;
    logic        done16;
    logic        start8;
    logic        start16;
    logic        done_s;
    logic [31:0] rle_s;

    assign start8  = start & ~sel;
    assign start16 = start & sel;
    assign done_s  = sel ? done16 : done8;
    assign rle_s   = sel ? rle_size16 : rle_size8;

`ifdef RLE_ABORT_EN
    logic abort;
    logic abort8;
    logic abort16;
    logic aborted8;
    logic aborted16;
    assign abort8  = abort & ~sel;
    assign abort16 = abort & sel;
`endif

    rle_engine_if #(.ADDR_W(16)) bus8 ();
    rle_engine_if #(.ADDR_W(16)) bus16 ();

    rle_engine #(.SYMBOL_W(8), .COUNT_W(8), .ADDR_W(16)) dut8 (
        .clk          (clk),
        .reset        (reset),
        .start        (start8),
        .message_addr (message_addr),
        .message_size (message_size),
        .rle_addr     (rle_addr),
        .rle_size     (rle_size8),
        .done         (done8),
`ifdef RLE_ABORT_EN
        .abort        (abort8),
        .aborted      (aborted8),
`endif
        .port_a       (bus8)
    );

    rle_engine #(.SYMBOL_W(16), .COUNT_W(16), .ADDR_W(16)) dut16 (
        .clk          (clk),
        .reset        (reset),
        .start        (start16),
        .message_addr (message_addr),
        .message_size (message_size),
        .rle_addr     (rle_addr),
        .rle_size     (rle_size16),
        .done         (done16),
`ifdef RLE_ABORT_EN
        .abort        (abort16),
        .aborted      (aborted16),
`endif
        .port_a       (bus16)
    );

    // Shared SRAM model: plaintext lives in mem, DUT writes go to a log.
    logic [31:0] mem [0:16383];
    logic [31:0] rdata;
    logic [15:0] s_addr;
    logic [31:0] s_din;
    logic        s_we;
    logic [15:0] wlog_a [$];
    logic [31:0] wlog_d [$];

    assign s_addr = sel ? bus16.port_A_addr    : bus8.port_A_addr;
    assign s_din  = sel ? bus16.port_A_data_in : bus8.port_A_data_in;
    assign s_we   = sel ? bus16.port_A_we      : bus8.port_A_we;
    assign bus8.port_A_data_out  = rdata;
    assign bus16.port_A_data_out = rdata;

    always @(posedge clk) begin
        rdata <= mem[s_addr[15:2]];
        if (s_we) begin
            wlog_a.push_back(s_addr);
            wlog_d.push_back(s_din);
        end
    end

    int          n_cmp = 0;
    int          n_err = 0;
    int          syms [$];
    logic [31:0] exp_words [$];
    int          exp_size;
    int          wbase;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: list of (count, symbol) pairs from the run rule, then packed.
    task automatic build_expect(input int sw, input int cw);
        longint      pairs [$];
        int          rs;
        int          rc;
        int          maxc;
        int          pw;
        int          per;
        logic [31:0] w;
        maxc = (1 << cw) - 1;
        pw   = sw + cw;
        per  = 32 / pw;
        rs   = 0;
        rc   = 0;
        exp_words.delete();
        foreach (syms[i]) begin
            if (i == 0) begin
                rs = syms[i];
                rc = 1;
            end else if (syms[i] == rs && rc < maxc) begin
                rc++;
            end else begin
                pairs.push_back((longint'(rc) << sw) | longint'(rs));
                rs = syms[i];
                rc = 1;
            end
        end
        if (syms.size() > 0) pairs.push_back((longint'(rc) << sw) | longint'(rs));
        exp_size = pairs.size() * pw / 8;
        for (int k = 0; k < pairs.size(); k += per) begin
            w = 32'd0;
            for (int j = 0; j < per; j++) begin
                if (k + j < pairs.size()) w = w | 32'(pairs[k+j] << (j * pw));
            end
            exp_words.push_back(w);
        end
    endtask

    task automatic load_syms(input int sw, input logic [31:0] maddr);
        for (int j = 0; j < syms.size(); j++) begin
            int          b;
            int          sh;
            logic [15:0] a;
            b  = j * (sw / 8);
            a  = 16'(maddr + 32'(b & ~3));
            sh = (b % 4) * 8;
            if (sw == 8) mem[a[15:2]][sh +: 8] = 8'(syms[j]);
            else         mem[a[15:2]][sh +: 16] = 16'(syms[j]);
        end
    endtask

    task automatic kick(input logic s, input logic [31:0] maddr, input logic [31:0] raddr,
                        input logic [31:0] nbytes);
        sel          = s;
        message_addr = maddr;
        rle_addr     = raddr;
        message_size = nbytes;
        wbase        = wlog_d.size();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("done_low_after_start", 32'(done_s), 32'd0);
    endtask

    task automatic wait_done(input int c0, output int cyc);
        cyc = c0;
        while (done_s !== 1'b1 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check("done_timeout", 32'(cyc < 3000), 32'd1);
    endtask

    task automatic verify(input string tag, input logic [31:0] raddr);
        int nw;
        nw = wlog_d.size() - wbase;
        check({tag, "_nwr"}, 32'(nw), 32'(exp_words.size()));
        for (int k = 0; k < exp_words.size() && k < nw; k++) begin
            check({tag, "_addr"}, 32'(wlog_a[wbase+k]),
                  ((raddr & 32'hFFFF_FFFC) + 32'(4 * k)) & 32'h0000_FFFF);
            check({tag, "_data"}, wlog_d[wbase+k], exp_words[k]);
        end
        check({tag, "_size"}, rle_s, 32'(exp_size));
    endtask

    initial begin
        int          cyc;
        int          n;
        int          v;
        int          rl;
        int          sw;
        int          snap;
        logic        s;
        logic [31:0] ma;
        logic [31:0] ra;

        reset        = 1'b1;
        start        = 1'b0;
        sel          = 1'b0;
        message_addr = 32'd0;
        message_size = 32'd0;
        rle_addr     = 32'd0;
`ifdef RLE_ABORT_EN
        abort = 1'b0;
`endif
        for (int i = 0; i < 16384; i++) mem[i] = 32'd0;
        repeat (3) @(negedge clk);

        check("rst_done8", 32'(done8), 32'd0);
        check("rst_done16", 32'(done16), 32'd0);
        check("rst_size8", rle_size8, 32'd0);
        check("rst_we8", 32'(bus8.port_A_we), 32'd0);
        check("rst_addr8", 32'(bus8.port_A_addr), 32'd0);
        check("rst_din8", bus8.port_A_data_in, 32'd0);
        check("port_clk8", 32'(bus8.port_A_clk), 32'(clk));
        check("port_clk16", 32'(bus16.port_A_clk), 32'(clk));
        reset = 1'b0;
        @(negedge clk);

        // Single word of 'A': one pair (4, 0x41), done in cycle 9.
        syms = {32'h41, 32'h41, 32'h41, 32'h41};
        load_syms(8, 32'h0);
        build_expect(8, 8);
        kick(1'b0, 32'h0, 32'h100, 32'd4);
        wait_done(1, cyc);
        check("single_cycle", 32'(cyc), 32'd9);
        check("single_nwr", 32'(wlog_d.size() - wbase), 32'd1);
        if (wlog_d.size() > wbase) begin
            check("single_data", wlog_d[wbase], 32'h0000_0441);
            check("single_addr", 32'(wlog_a[wbase]), 32'h100);
        end
        check("single_size", rle_size8, 32'd2);
        verify("single", 32'h100);
        repeat (3) @(negedge clk);
        check("size_stable_in_done", rle_size8, 32'd2);
        check("done_level", 32'(done8), 32'd1);

        // start held high through SCAN must not disturb the frame.
        kick(1'b0, 32'h0, 32'h180, 32'd4);
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        repeat (4) @(negedge clk);
        start = 1'b0;
        wait_done(7, cyc);
        check("held_start_cycle", 32'(cyc), 32'd9);
        verify("held_start", 32'h180);

        // 300 zero bytes saturate the counter once.
        syms.delete();
        repeat (300) syms.push_back(0);
        load_syms(8, 32'h400);
        build_expect(8, 8);
        kick(1'b0, 32'h400, 32'h200, 32'd300);
        wait_done(1, cyc);
        if (wlog_d.size() > wbase) check("sat_data", wlog_d[wbase], 32'h2D00_FF00);
        check("sat_size", rle_size8, 32'd4);
        verify("sat", 32'h200);

        // Mixed runs across two input words.
        syms = {1, 1, 2, 3, 3, 3, 4, 4};
        load_syms(8, 32'h800);
        build_expect(8, 8);
        kick(1'b0, 32'h800, 32'h300, 32'd8);
        wait_done(1, cyc);
        check("mixed_size", rle_size8, 32'd8);
        verify("mixed", 32'h300);

        // Wide 16/16 build.
        syms = {32'hBEEF, 32'hBEEF, 32'hBEEF, 32'h1234};
        load_syms(16, 32'hC00);
        build_expect(16, 16);
        kick(1'b1, 32'hC00, 32'h340, 32'd8);
        wait_done(1, cyc);
        if (wlog_d.size() > wbase + 1) begin
            check("wide_data0", wlog_d[wbase], 32'h0003_BEEF);
            check("wide_data1", wlog_d[wbase+1], 32'h0001_1234);
        end
        verify("wide", 32'h340);

        // Empty frame: straight through FLUSH, no SRAM access.
        syms.delete();
        build_expect(8, 8);
        kick(1'b0, 32'h0, 32'h380, 32'd0);
        wait_done(1, cyc);
        check("empty_cycle", 32'(cyc), 32'd2);
        check("empty_done", 32'(done8), 32'd1);
        verify("empty", 32'h380);

        // Randomized frames on both builds, including address wrap.
        for (int t = 0; t < 12; t++) begin
            s  = t[0];
            sw = s ? 16 : 8;
            syms.delete();
            n = $urandom_range(1, 40);
            while (syms.size() < n) begin
                v  = $urandom_range(0, 3) + (s ? 32'hBE00 : 32'h30);
                rl = ($urandom_range(0, 9) == 0) ? $urandom_range(250, 262) : $urandom_range(1, 5);
                repeat (rl) syms.push_back(v);
            end
            ma = $urandom & 32'hFFFF_FFFC;
            ra = (t == 2) ? 32'h0001_FFF8 : ($urandom & 32'hFFFF_FFFC);
            load_syms(sw, ma);
            build_expect(sw, sw);
            kick(s, ma, ra, 32'(syms.size() * sw / 8));
            wait_done(1, cyc);
            verify(s ? "rand16" : "rand8", ra);
        end

        // Reset while a write is on the bus.
        syms = {32'h41, 32'h41, 32'h41, 32'h41};
        load_syms(8, 32'h0);
        kick(1'b0, 32'h0, 32'h500, 32'd4);
        cyc = 1;
        while (s_we !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_wr_seen", 32'(s_we), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("rst_wr_we", 32'(bus8.port_A_we), 32'd0);
        check("rst_wr_addr", 32'(bus8.port_A_addr), 32'd0);
        check("rst_wr_din", bus8.port_A_data_in, 32'd0);
        check("rst_wr_done", 32'(done8), 32'd0);
        check("rst_wr_size", rle_size8, 32'd0);
        snap  = wlog_d.size();
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("rst_no_more_wr", 32'(wlog_d.size()), 32'(snap));
        check("rst_stays_idle", 32'(done8), 32'd0);

`ifdef RLE_ABORT_EN
        // Abort after the first word is written: only that word counts.
        syms.delete();
        for (int j = 1; j <= 16; j++) syms.push_back(j);
        load_syms(8, 32'h600);
        kick(1'b0, 32'h600, 32'h700, 32'd16);
        cyc = 1;
        while (s_we !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("abort_wr_seen", 32'(s_we), 32'd1);
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_done", 32'(done8), 32'd1);
        check("abort_flag", 32'(aborted8), 32'd1);
        check("abort_size", rle_size8, 32'd4);
        repeat (5) @(negedge clk);
        check("abort_nwr", 32'(wlog_d.size() - wbase), 32'd1);
        kick(1'b0, 32'h0, 32'h780, 32'd0);
        check("abort_flag_clear", 32'(aborted8), 32'd0);
        wait_done(1, cyc);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
